vga_capture: RTL and testbench
==============================

# vga_capture

Video-input counterpart of the display timing generator: consumes a 640x480@60 VGA-style stream (active-low hsync/vsync, active-high valid, 24-bit RGB) on the pixel clock and writes each active pixel into a framebuffer write port. It also locks onto frame boundaries and checks line and frame geometry. It sits between a video source, such as a loopback of our own display output or an external sensor bridge, and the dual-port framebuffer RAM.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_TOTAL, 800, pclk cycles per line (hsync falling edge to next)
- ADDR_W, 19, framebuffer address width (must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE)

Ports:
- pclk  in  1  pixel clock, 25 MHz
- reset  in  1  synchronous, active-low reset
- capture_en  in  1  level; 1 = capture frames continuously
- hsync  in  1  line sync, active low
- vsync  in  1  frame sync, active low
- valid  in  1  active-video qualifier
- vga_r / vga_g / vga_b  in  8 each  pixel colour
- wr_en  out  1  framebuffer write strobe
- wr_addr  out  ADDR_W  pixel address = line*H_ACTIVE + column
- wr_data  out  24  {r,g,b}
- frame_done  out  1  one-cycle pulse after a complete, error-free frame
- locked  out  1  at least one good frame captured and no error since
- err_hlen  out  1  sticky; an active run had a length other than H_ACTIVE
- err_htotal  out  1  sticky; a line period differed from H_TOTAL
- err_vlen  out  1  sticky; a frame held a number of active lines other than V_ACTIVE

## Operation
- Input stage: all of hsync, vsync, valid and rgb are registered once (stage S1), with a second copy of hsync/vsync/valid kept for edge detection. Frame start (FS) = vsync falling edge. Line start (LS) = hsync falling edge. Run end (RE) = valid falling edge.
- FSM states are IDLE, WAIT_FRAME and CAPTURE.
  - IDLE: no writes. capture_en=1 -> WAIT_FRAME, and all err_* flags clear.
  - WAIT_FRAME: no writes. FS -> CAPTURE, with the counters cleared (col=0, line=0, line_base=0, htick=0).
  - CAPTURE: each S1 cycle with valid=1 and col<H_ACTIVE and line<V_ACTIVE writes pixel at line_base+col, then col++. Pixels beyond those bounds are dropped (no write, no address wrap).
  - CAPTURE, on RE:
    - If col != H_ACTIVE, set err_hlen.
    - Then col=0, line++ and line_base += H_ACTIVE, both saturating at V_ACTIVE.
  - CAPTURE, htick: counts pclk cycles between consecutive LS. On each LS after the first in the frame, if htick != H_TOTAL, set err_htotal. htick restarts at 1 on LS and saturates at 1023.
  - CAPTURE, on FS:
    - If line != V_ACTIVE, set err_vlen.
    - Otherwise, if no err_* is set, pulse frame_done and set locked.
    - Counters are then cleared for the next frame.
    - If capture_en=0 at FS -> IDLE; otherwise remain in CAPTURE.
  - capture_en=0 in any state -> IDLE on the next edge, with writes stopped immediately. err_* flags hold their values until the next 0->1 transition.
- locked clears whenever any err_* sets, or on leaving CAPTURE.
- Address arithmetic is a running line_base plus col. No multiplier.

## Timing
- Reset (reset=0 at a pclk edge): state=IDLE; wr_en=0, wr_addr=0, wr_data=0, frame_done=0, locked=0, all err_*=0; all counters=0.
- Latency: a pixel present at the input pins before edge N is in S1 after N. wr_en, wr_addr and wr_data are registered and valid after edge N+1, so the pin-to-write-port latency is 2 cycles, with one write per cycle and no backpressure.
- frame_done is asserted for exactly 1 cycle, the cycle after the FS-detect edge. Error flags update on the same edge as the event that detects them.
- FS and RE on the same cycle: RE is processed first, then the FS frame check.
- Reset mid-frame: outputs return to their reset values on that edge. The partial frame is discarded, and capture restarts only via IDLE -> WAIT_FRAME -> FS.
- capture_en asserted mid-frame: the remainder of that frame is ignored.

## Test plan
- Nominal stream (800x525 timing, 640x480 active, pixel={x[7:0],y[7:0],8'h5A}), capture_en=1 -> 307200 writes per frame, addresses 0..307199 in order, wr_data matches pixel at addr, frame_done exactly once per frame, locked=1 after first frame end, no err_*.
- capture_en raised at line 200 of a frame -> zero writes until next vsync falling edge; the following frame is captured fully.
- One line with 639 valid pixels -> err_hlen=1, locked=0, no frame_done for that frame; that line's writes end at col 638 and the next line still starts at its own line_base.
- One line of 801 cycles -> err_htotal=1; extra 30 active lines (510) -> err_vlen=1, and writes stop at addr 307199.
- Reset (reset=0) for 1 cycle at pixel (320,240) -> next cycle wr_en=0, locked=0; writes resume at addr 0 only after a new FS.
- capture_en dropped mid-line -> wr_en=0 within 1 cycle of the registered drop; re-raise clears err_* and waits for FS.

Source files
------------

// File: rtl/vga_capture.sv
// Captures a VGA-style RGB stream into a framebuffer write port and checks
// the line and frame geometry against the expected timing.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int ADDR_W   = 19
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              valid,
  input  logic [7:0]        vga_r,
  input  logic [7:0]        vga_g,
  input  logic [7:0]        vga_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              frame_done,
  output logic              locked,
  output logic              err_hlen,
  output logic              err_htotal,
  output logic              err_vlen
);
  localparam int COL_W  = $clog2(H_ACTIVE + 2);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0]  H_A   = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0]  H_SAT = COL_W'(H_ACTIVE + 1);
  localparam logic [LINE_W-1:0] V_A   = LINE_W'(V_ACTIVE);
  localparam logic [9:0]        H_T   = 10'(H_TOTAL);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;
  state_t state;

  logic        hs1, vs1, vld1, hs2, vs2, vld2;
  logic [23:0] rgb1;
  logic        fs, ls, re;

  always_ff @(posedge pclk) begin
    if (!reset) begin
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      vld1 <= 1'b0;
      hs2  <= 1'b1;
      vs2  <= 1'b1;
      vld2 <= 1'b0;
      rgb1 <= '0;
    end else begin
      hs1  <= hsync;
      vs1  <= vsync;
      vld1 <= valid;
      rgb1 <= {vga_r, vga_g, vga_b};
      hs2  <= hs1;
      vs2  <= vs1;
      vld2 <= vld1;
    end
  end

  assign fs = vs2 & ~vs1;
  assign ls = hs2 & ~hs1;
  assign re = vld2 & ~vld1;

  // col counts every valid pixel (saturating just past H_ACTIVE) so that
  // over-long runs are still caught; only in-bounds pixels are written.
  logic [COL_W-1:0]  col, col_n;
  logic [LINE_W-1:0] line, line_n;
  logic [ADDR_W-1:0] line_base, base_n;
  logic              line_ovf, ovf_n;
  logic [9:0]        htick, htick_n;
  logic              ls_seen;
  logic              pix_ok, hlen_hit, htot_hit, vlen_hit, e_h, e_t, e_v;

  always_comb begin
    col_n    = col;
    line_n   = line;
    base_n   = line_base;
    ovf_n    = line_ovf;
    hlen_hit = 1'b0;
    pix_ok   = vld1 && (col < H_A) && (line < V_A);
    if (vld1 && col != H_SAT) col_n = col + 1'b1;
    if (re) begin
      hlen_hit = (col != H_A);
      col_n    = '0;
      if (line == V_A) ovf_n = 1'b1;
      else begin
        line_n = line + 1'b1;
        base_n = line_base + ADDR_W'(H_ACTIVE);
      end
    end
    htick_n  = ls ? 10'd1 : (htick == 10'h3FF ? htick : htick + 1'b1);
    htot_hit = ls && ls_seen && (htick != H_T);
    // Frame check sees the line count after any same-cycle run end.
    vlen_hit = fs && ((line_n != V_A) || ovf_n);
    e_h      = err_hlen | hlen_hit;
    e_t      = err_htotal | htot_hit;
    e_v      = err_vlen | vlen_hit;
  end

  always_ff @(posedge pclk) begin
    if (!reset) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      err_hlen   <= 1'b0;
      err_htotal <= 1'b0;
      err_vlen   <= 1'b0;
      col        <= '0;
      line       <= '0;
      line_base  <= '0;
      line_ovf   <= 1'b0;
      htick      <= '0;
      ls_seen    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (!capture_en) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state      <= WAIT_FRAME;
            err_hlen   <= 1'b0;
            err_htotal <= 1'b0;
            err_vlen   <= 1'b0;
          end
          WAIT_FRAME: if (fs) begin
            state     <= CAPTURE;
            col       <= '0;
            line      <= '0;
            line_base <= '0;
            line_ovf  <= 1'b0;
            htick     <= '0;
            ls_seen   <= 1'b0;
          end
          CAPTURE: begin
            wr_en <= pix_ok;
            if (pix_ok) begin
              wr_addr <= line_base + ADDR_W'(col);
              wr_data <= rgb1;
            end
            err_hlen   <= e_h;
            err_htotal <= e_t;
            err_vlen   <= e_v;
            if (hlen_hit || htot_hit || vlen_hit) locked <= 1'b0;
            if (fs) begin
              if (!(e_h || e_t || e_v)) begin
                frame_done <= 1'b1;
                locked     <= 1'b1;
              end
              col       <= '0;
              line      <= '0;
              line_base <= '0;
              line_ovf  <= 1'b0;
              htick     <= '0;
              ls_seen   <= 1'b0;
            end else begin
              col       <= col_n;
              line      <= line_n;
              line_base <= base_n;
              line_ovf  <= ovf_n;
              htick     <= htick_n;
              if (ls) ls_seen <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vga_capture.sv
// Frame-level randomized bench for vga_capture: a per-frame reference model
// queues expected writes and flags; a monitor compares every write strobe.
module tb_vga_capture;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int HT = 24;
  localparam int AW = 8;

  logic          pclk = 1'b0;
  logic          reset, capture_en, hsync, vsync, valid;
  logic [7:0]    vga_r, vga_g, vga_b;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          frame_done, locked, err_hlen, err_htotal, err_vlen;

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .H_TOTAL(HT), .ADDR_W(AW)) dut (
    .pclk(pclk), .reset(reset), .capture_en(capture_en),
    .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .locked(locked),
    .err_hlen(err_hlen), .err_htotal(err_htotal), .err_vlen(err_vlen)
  );

  always #5 pclk = ~pclk;

  typedef struct packed { logic [AW-1:0] a; logic [23:0] d; } wr_t;
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          n_pass = 0, n_tot = 0, fd_cnt = 0;
  int          ms = 0;  // model: 0 idle, 1 waiting for frame start, 2 capturing
  bit          m_hlen, m_htot, m_vlen, m_locked, exp_done;
  logic [23:0] pix [16][24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  always @(negedge pclk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_write_addr", 32'(wr_addr), 32'hFFFF_FFFF);
      else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.a));
        check("wr_data", 32'(wr_data), 32'(mon_e.d));
      end
    end
  end

  // One frame: nact active lines, then 2 blank, 2 vsync-low, 2 blank lines.
  // bad_l gets run length bad_len, long_l gets a period of HT+1,
  // rst_l gets a one-cycle reset during its horizontal blanking.
  task automatic run_frame(input bit ce, input int nact, input int bad_l, input int bad_len,
                           input int long_l, input int rst_l);
    int  len[16];
    bit  cap;
    for (int l = 0; l < 16; l++) begin
      len[l] = (l == bad_l) ? bad_len : H;
      for (int x = 0; x < 24; x++) pix[l][x] = 24'($urandom);
    end
    exp_done = 1'b0;
    if (!ce) begin
      ms = 0;
      m_locked = 1'b0;
    end else begin
      if (ms == 0) begin
        m_hlen = 1'b0; m_htot = 1'b0; m_vlen = 1'b0;
        ms = 1;
      end
      cap = (ms == 2);
      if (cap)
        for (int l = 0; l < nact && l < V; l++)
          if (rst_l < 0 || l <= rst_l)
            for (int x = 0; x < len[l] && x < H; x++)
              exp_q.push_back('{a: AW'(l * H + x), d: pix[l][x]});
      if (rst_l >= 0) begin
        m_hlen = 1'b0; m_htot = 1'b0; m_vlen = 1'b0; m_locked = 1'b0;
      end else if (cap) begin
        if (bad_l >= 0 && bad_len != H) m_hlen = 1'b1;
        if (long_l >= 0) m_htot = 1'b1;
        if (nact != V) m_vlen = 1'b1;
        if (m_hlen || m_htot || m_vlen) m_locked = 1'b0;
        else begin
          exp_done = 1'b1;
          m_locked = 1'b1;
        end
      end
      ms = 2;
    end

    fd_cnt = 0;
    capture_en = ce;
    for (int l = 0; l < nact + 6; l++) begin
      int per;
      per = (l == long_l) ? HT + 1 : HT;
      for (int x = 0; x < per; x++) begin
        hsync = !(x >= 18 && x <= 20);
        vsync = !(l == nact + 2 || l == nact + 3);
        valid = (l < nact) && (x < len[l]);
        {vga_r, vga_g, vga_b} = valid ? pix[l][x] : 24'h0;
        reset = !(l == rst_l && x == 20);
        tick();
        if (l == rst_l && x == 20) begin
          check("rst_wr_en", 32'(wr_en), 32'd0);
          check("rst_locked", 32'(locked), 32'd0);
          check("rst_errs", 32'({err_hlen, err_htotal, err_vlen}), 32'd0);
        end
      end
    end
    reset = 1'b1;

    check("frame_done_count", 32'(fd_cnt), 32'(exp_done));
    check("locked", 32'(locked), 32'(m_locked));
    check("err_hlen", 32'(err_hlen), 32'(m_hlen));
    check("err_htotal", 32'(err_htotal), 32'(m_htot));
    check("err_vlen", 32'(err_vlen), 32'(m_vlen));
    check("missing_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int k;
    bit ce;
    reset = 1'b0; capture_en = 1'b0; hsync = 1'b1; vsync = 1'b1; valid = 1'b0;
    vga_r = 8'h0; vga_g = 8'h0; vga_b = 8'h0;
    repeat (3) tick();
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);
    check("reset_wr_data", 32'(wr_data), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_errs", 32'({err_hlen, err_htotal, err_vlen}), 32'd0);
    reset = 1'b1;

    run_frame(1, V, -1, 0, -1, -1);      // arm: waits for frame start
    run_frame(1, V, -1, 0, -1, -1);      // first captured frame
    run_frame(1, V, -1, 0, -1, -1);
    run_frame(1, V, 3, H - 1, -1, -1);   // short run
    run_frame(0, V, -1, 0, -1, -1);
    run_frame(1, V, -1, 0, -1, -1);
    run_frame(1, V, -1, 0, -1, -1);
    run_frame(1, V, -1, 0, 2, -1);       // long line period
    run_frame(0, V, -1, 0, -1, -1);
    run_frame(1, V, -1, 0, -1, -1);
    run_frame(1, V + 2, -1, 0, -1, -1);  // extra active lines
    run_frame(0, V, -1, 0, -1, -1);
    run_frame(1, V, -1, 0, -1, -1);
    run_frame(1, V, -1, 0, -1, -1);
    run_frame(1, V, -1, 0, -1, 2);       // reset mid-frame
    run_frame(1, V, -1, 0, -1, -1);

    for (int i = 0; i < 10; i++) begin
      k  = $urandom_range(0, 5);
      ce = ($urandom_range(0, 4) != 0);
      case (k)
        3:       run_frame(ce, V, $urandom_range(0, V - 1), ($urandom_range(0, 1) != 0) ? H - 1 : H + 1, -1, -1);
        4:       run_frame(ce, V, -1, 0, $urandom_range(0, V - 2), -1);
        5:       run_frame(ce, ($urandom_range(0, 1) != 0) ? V - 1 : V + 2, -1, 0, -1, -1);
        default: run_frame(ce, V, -1, 0, -1, -1);
      endcase
    end

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
